y86_trace_fifo: RTL and testbench
=================================

# y86_trace_fifo

Per-instruction execution trace unit that sits directly downstream of the y86 sequential core's memory bus. It snoops every bus cycle and assembles one record per retired instruction: fetch address, instruction word, and an optional data access. Records are buffered in a FIFO and drained through a valid/ready debug port. It is observe-only and never drives the core's bus.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- CW, 16: width of the drop counter.
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  high allows new records to open.
- ifetch  in  1  high in the core's fetch cycle; qualifies bus_RE as an instruction fetch. The top level ties it to the core's fetch phase.
- flush  in  1  one-cycle pulse; closes the open record.
- bus_A  in  32  core bus address.
- bus_in  in  32  read data to the core.
- bus_out  in  32  write data from the core.
- bus_RE  in  1  core read strobe.
- bus_WE  in  1  core write strobe.
- trace_valid  out  1  head record available.
- trace_ready  in  1  consumer accepts the head record.
- trace_data  out  130  head record: {kind[1:0], pc[31:0], instr[31:0], maddr[31:0], mdata[31:0]}, kind in the MSBs.
- level  out  log2(DEPTH)+1  current occupancy.
- drop_cnt  out  CW  records lost to overflow; saturates.

## Operation
- Record register (open flag plus fields) assembles the current instruction.
- **Fetch** (bus_RE && ifetch):
  - If a record is open, it is closed and pushed.
  - If enable is high, a new record opens with pc=bus_A, instr=bus_in, kind=0, maddr=0, mdata=0.
  - If enable is low, no new record opens and the open flag clears.
- **Load** (bus_RE && !ifetch, record open): kind=1, maddr=bus_A, mdata=bus_in.
- **Store** (bus_WE, record open): kind=2, maddr=bus_A, mdata=bus_out.
- A second data access in one record overwrites the first; the last one wins.
- Data accesses with no open record are ignored.
- **flush**: closes and pushes the open record. No-op if none is open.
- flush in the same cycle as a fetch: the fetch handling applies and flush is ignored.
- kind=3 is never produced.
- **FIFO**:
  - Circular buffer with AW-bit read/write pointers and a separate occupancy counter.
  - Show-ahead: trace_data is the head entry whenever trace_valid is high.
  - trace_data contents are don't-care when trace_valid is low.
  - Pop on trace_valid && trace_ready.
- **Push/pop arbitration**:
  - Push when not full, or when full with a pop in the same cycle.
  - Simultaneous push and pop: level unchanged; both pointers advance, wrapping at DEPTH.
  - Push when full with no pop: the record is dropped and drop_cnt increments, saturating at 2^CW-1.
  - Pop when empty: impossible, since valid is low.
- **Reset** (rst_n low, asynchronous):
  - Pointers 0, level 0, trace_valid 0.
  - Record closed, drop_cnt 0.
  - FIFO storage is not reset.
  - Reset mid-operation discards the open record and all buffered records.

## Timing
- Record capture occurs on the edge where the strobe is sampled high.
- Push of a closed record occurs on the same edge that opens the next record.
- A closed record is visible on trace_data with trace_valid=1 one cycle after the closing edge (the FIFO was empty).
- Pop takes effect on the accepting edge; the next entry is presented in the following cycle.
- level and drop_cnt are registered and update on the same edge as the push or pop.
- trace_ready may toggle freely; valid never depends combinationally on ready.
- With the core's 5-cycle instruction period, steady-state input is at most one push per 5 cycles.

## Test plan
- **Reset**: assert rst_n=0 mid-cycle -> trace_valid=0, level=0, drop_cnt=0 immediately.
- **Store record**:
  - Stimulus: fetch at bus_A=0x10 with bus_in=0x00004589; three cycles later bus_WE with bus_A=0x200, bus_out=0xDEADBEEF; next fetch at 0x13.
  - Response: one record with kind=2, pc=0x10, instr=0x00004589, maddr=0x200, mdata=0xDEADBEEF; level=1.
- **Load, then flush**:
  - Stimulus: fetch at 0x20; load at 0x300 returning 0x12345678; flush.
  - Response: record with kind=1, maddr=0x300, mdata=0x12345678.
  - A second flush adds nothing.
- **Overflow**:
  - Stimulus: hold trace_ready=0 and generate 20 records with DEPTH=16.
  - Response: level=16, drop_cnt=4; draining returns the first 16 records in order, with pc values intact across pointer wrap.
- **Full with simultaneous push and pop**:
  - Stimulus: FIFO full, trace_ready=1 on the edge where a push occurs.
  - Response: level stays 16, drop_cnt unchanged, the new record sits last.
- **Enable and flush edges**:
  - enable=0 during a fetch closes the prior record with no new record opening; later loads are ignored.
  - flush coincident with a fetch yields exactly one push.

Source files
------------

// File: rtl/y86_trace_fifo.sv
// y86_trace_fifo: per-instruction execution trace unit for the y86 sequential core.
// Snoops the core memory bus and assembles one record per retired instruction
// (fetch address, instruction word, optional data access), buffers records in a
// show-ahead FIFO and drains them over a valid/ready debug port. Observe-only.
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   enable            allows new records to open at a fetch
//   ifetch            qualifies bus_RE as an instruction fetch
//   flush             one-cycle pulse closing the open record
//   bus_A/in/out      core bus address, read data, write data
//   bus_RE, bus_WE    core read / write strobes
//   trace_valid/ready/data  debug drain port, data = {kind, pc, instr, maddr, mdata}
//   level             FIFO occupancy
//   drop_cnt          saturating count of records lost to overflow
module y86_trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          ifetch,
  input  logic          flush,
  input  logic [31:0]   bus_A,
  input  logic [31:0]   bus_in,
  input  logic [31:0]   bus_out,
  input  logic          bus_RE,
  input  logic          bus_WE,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [129:0]  trace_data,
  output logic [LW-1:0] level,
  output logic [CW-1:0] drop_cnt
);

  localparam logic [1:0] KindNone  = 2'd0;
  localparam logic [1:0] KindLoad  = 2'd1;
  localparam logic [1:0] KindStore = 2'd2;

  // Record register
  logic        rec_open_q, rec_open_d;
  logic [1:0]  rec_kind_q, rec_kind_d;
  logic [31:0] rec_pc_q, rec_pc_d;
  logic [31:0] rec_instr_q, rec_instr_d;
  logic [31:0] rec_maddr_q, rec_maddr_d;
  logic [31:0] rec_mdata_q, rec_mdata_d;

  logic         fetch;
  logic         push_req;
  logic [129:0] push_rec;

  // FIFO state
  logic [129:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] drop_cnt_q;
  logic          full, push, pop, drop;

  assign fetch    = bus_RE && ifetch;
  assign push_rec = {rec_kind_q, rec_pc_q, rec_instr_q, rec_maddr_q, rec_mdata_q};

  // Fetch outranks flush; data accesses only land in an open record and only
  // when the cycle neither fetches nor flushes. A store outranks a load.
  always_comb begin
    rec_open_d  = rec_open_q;
    rec_kind_d  = rec_kind_q;
    rec_pc_d    = rec_pc_q;
    rec_instr_d = rec_instr_q;
    rec_maddr_d = rec_maddr_q;
    rec_mdata_d = rec_mdata_q;
    push_req    = 1'b0;
    if (fetch) begin
      push_req   = rec_open_q;
      rec_open_d = enable;
      if (enable) begin
        rec_kind_d  = KindNone;
        rec_pc_d    = bus_A;
        rec_instr_d = bus_in;
        rec_maddr_d = '0;
        rec_mdata_d = '0;
      end
    end else if (flush) begin
      push_req   = rec_open_q;
      rec_open_d = 1'b0;
    end else if (rec_open_q) begin
      if (bus_WE) begin
        rec_kind_d  = KindStore;
        rec_maddr_d = bus_A;
        rec_mdata_d = bus_out;
      end else if (bus_RE) begin
        rec_kind_d  = KindLoad;
        rec_maddr_d = bus_A;
        rec_mdata_d = bus_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_open_q  <= 1'b0;
      rec_kind_q  <= KindNone;
      rec_pc_q    <= '0;
      rec_instr_q <= '0;
      rec_maddr_q <= '0;
      rec_mdata_q <= '0;
    end else begin
      rec_open_q  <= rec_open_d;
      rec_kind_q  <= rec_kind_d;
      rec_pc_q    <= rec_pc_d;
      rec_instr_q <= rec_instr_d;
      rec_maddr_q <= rec_maddr_d;
      rec_mdata_q <= rec_mdata_d;
    end
  end

  // Push/pop arbitration: a full FIFO still accepts a push if the head leaves
  // on the same edge.
  assign trace_valid = (level_q != '0);
  assign pop         = trace_valid && trace_ready;
  assign full        = (level_q == LW'(DEPTH));
  assign push        = push_req && (!full || pop);
  assign drop        = push_req && full && !pop;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop && (drop_cnt_q != {CW{1'b1}})) drop_cnt_q <= drop_cnt_q + CW'(1);
    end
  end

  // Storage carries no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_rec;
  end

  assign trace_data = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_y86_trace_fifo.sv
// Directed self-checking bench for y86_trace_fifo (DEPTH=16, CW=16).
module tb_y86_trace_fifo;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         ifetch;
  logic         flush;
  logic [31:0]  bus_A;
  logic [31:0]  bus_in;
  logic [31:0]  bus_out;
  logic         bus_RE;
  logic         bus_WE;
  logic         trace_valid;
  logic         trace_ready;
  logic [129:0] trace_data;
  logic [4:0]   level;
  logic [15:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  y86_trace_fifo #(
    .DEPTH(16),
    .CW   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .ifetch     (ifetch),
    .flush      (flush),
    .bus_A      (bus_A),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_RE     (bus_RE),
    .bus_WE     (bus_WE),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_data (trace_data),
    .level      (level),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [129:0] rec(input logic [1:0] kind, input logic [31:0] pc,
                                       input logic [31:0] instr, input logic [31:0] maddr,
                                       input logic [31:0] mdata);
    return {kind, pc, instr, maddr, mdata};
  endfunction

  // One bus cycle; called #1 after an edge, returns #1 after the next edge.
  task automatic cyc(input bit re, input bit we, input bit ifs, input bit fl,
                     input logic [31:0] a, input logic [31:0] din, input logic [31:0] dout);
    bus_RE  = re;
    bus_WE  = we;
    ifetch  = ifs;
    flush   = fl;
    bus_A   = a;
    bus_in  = din;
    bus_out = dout;
    @(posedge clk);
    #1;
    bus_RE  = 1'b0;
    bus_WE  = 1'b0;
    ifetch  = 1'b0;
    flush   = 1'b0;
    bus_A   = '0;
    bus_in  = '0;
    bus_out = '0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] instr);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, a, instr, 32'h0);
  endtask

  task automatic do_flush();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic pop_one();
    trace_ready = 1'b1;
    @(posedge clk);
    #1;
    trace_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; ifetch = 1'b0; flush = 1'b0;
    bus_A = '0; bus_in = '0; bus_out = '0; bus_RE = 1'b0; bus_WE = 1'b0;
    trace_ready = 1'b0;

    // Reset state
    #12;
    check("rst_valid", 130'(trace_valid), 130'd0);
    check("rst_level", 130'(level), 130'd0);
    check("rst_drop", 130'(drop_cnt), 130'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store record
    fetch(32'h10, 32'h0000_4589);
    idle();
    idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF);
    check("st_level_open", 130'(level), 130'd0);
    fetch(32'h13, 32'h0000_6020);
    check("st_level", 130'(level), 130'd1);
    check("st_valid", 130'(trace_valid), 130'd1);
    check("st_rec", trace_data, rec(2'd2, 32'h10, 32'h4589, 32'h200, 32'hDEAD_BEEF));
    pop_one();
    check("st_pop_level", 130'(level), 130'd0);

    // Load then flush; the 0x20 fetch first closes the plain 0x13 record
    fetch(32'h20, 32'h0000_5001);
    check("ld_prev_rec", trace_data, rec(2'd0, 32'h13, 32'h6020, 32'h0, 32'h0));
    pop_one();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h1234_5678, 32'h0);
    do_flush();
    check("ld_level", 130'(level), 130'd1);
    check("ld_rec", trace_data, rec(2'd1, 32'h20, 32'h5001, 32'h300, 32'h1234_5678));
    do_flush();
    check("ld_flush2_level", 130'(level), 130'd1);
    pop_one();

    // enable=0 fetch closes the prior record and opens none
    fetch(32'h40, 32'h0000_1111);
    enable = 1'b0;
    fetch(32'h44, 32'h0000_2222);
    check("en_level", 130'(level), 130'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'hCAFE_0000, 32'h0);
    do_flush();
    check("en_ignored_level", 130'(level), 130'd1);
    check("en_rec", trace_data, rec(2'd0, 32'h40, 32'h1111, 32'h0, 32'h0));
    pop_one();
    enable = 1'b1;

    // flush coincident with a fetch: one push only
    fetch(32'h50, 32'h0000_3333);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h54, 32'h0000_4444, 32'h0);
    check("ff_level", 130'(level), 130'd1);
    check("ff_rec", trace_data, rec(2'd0, 32'h50, 32'h3333, 32'h0, 32'h0));
    pop_one();
    do_flush();
    check("ff_open_rec", trace_data, rec(2'd0, 32'h54, 32'h4444, 32'h0, 32'h0));
    pop_one();
    check("ff_empty", 130'(level), 130'd0);

    // Overflow: 20 records, ready held low; pointers start at 6 so they wrap
    for (int i = 0; i < 20; i++) begin
      fetch(32'h1000 + 32'(4 * i), 32'h100 + 32'(i));
      do_flush();
    end
    check("ov_level", 130'(level), 130'd16);
    check("ov_drop", 130'(drop_cnt), 130'd4);
    check("ov_head", trace_data, rec(2'd0, 32'h1000, 32'h100, 32'h0, 32'h0));

    // Full with simultaneous push and pop
    fetch(32'h2000, 32'h0000_00AA);
    trace_ready = 1'b1;
    do_flush();
    trace_ready = 1'b0;
    check("pp_level", 130'(level), 130'd16);
    check("pp_drop", 130'(drop_cnt), 130'd4);

    // Drain: 0x1004..0x103C then the 0x2000 record last
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain_%0d", i), trace_data,
            rec(2'd0, 32'h1000 + 32'(4 * i), 32'h100 + 32'(i), 32'h0, 32'h0));
      pop_one();
    end
    check("drain_last", trace_data, rec(2'd0, 32'h2000, 32'hAA, 32'h0, 32'h0));
    pop_one();
    check("drain_level", 130'(level), 130'd0);
    check("drain_valid", 130'(trace_valid), 130'd0);

    // Reset mid-operation discards buffered and open records
    fetch(32'h60, 32'h0000_7777);
    do_flush();
    fetch(32'h64, 32'h0000_8888);
    check("mr_level_pre", 130'(level), 130'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_valid", 130'(trace_valid), 130'd0);
    check("mr_level", 130'(level), 130'd0);
    check("mr_drop", 130'(drop_cnt), 130'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // No open record after reset: store ignored and flush pushes nothing
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h1);
    do_flush();
    check("mr_after_level", 130'(level), 130'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
